// File: rtl/mvm_stream.sv
// Streaming signed matrix-vector multiplier y = A*x with serial operand/result handshakes.
// A may be kept across runs; per-row results either wrap or saturate to OUTPUT_WIDTH.
module mvm_stream #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter bit SATURATE     = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           keep_matrix,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic signed [INPUT_WIDTH-1:0]  s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic signed [OUTPUT_WIDTH-1:0] m_data,
  output logic                           busy,
  output logic                           done,
  output logic                           sat
);
  localparam int NA  = ROWS * COLS;
  localparam int PW  = 2 * INPUT_WIDTH;
  localparam int AW  = PW + $clog2(COLS) + 1;
  localparam int WW  = ((AW > OUTPUT_WIDTH) ? AW : OUTPUT_WIDTH) + 1;
  localparam int AIW = (NA > 1) ? $clog2(NA) : 1;
  localparam int XIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic signed [WW-1:0] MAXV = (WW'(1) <<< (OUTPUT_WIDTH - 1)) - WW'(1);
  localparam logic signed [WW-1:0] MINV = -MAXV - WW'(1);

  // state   | meaning
  // IDLE    | waiting for start
  // LOAD_A  | accepting ROWS*COLS matrix beats, row-major
  // LOAD_X  | accepting COLS vector beats
  // COMPUTE | one MAC per cycle, row-major
  // OUTPUT  | streaming y[0..ROWS-1]
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT} state_t;

  state_t                    state_q;
  logic [AIW-1:0]            a_idx_q;
  logic [XIW-1:0]            col_q;
  logic [YIW-1:0]            row_q;
  logic [YIW-1:0]            k_q;
  logic                      mat_ok_q;
  logic                      s_ready_q;
  logic                      m_valid_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      sat_q;
  logic signed [OUTPUT_WIDTH-1:0] m_data_q;

  logic signed [INPUT_WIDTH-1:0]  a_q [NA];
  logic signed [INPUT_WIDTH-1:0]  x_q [COLS];
  logic signed [OUTPUT_WIDTH-1:0] y_q [ROWS];
  logic signed [AW-1:0]           acc_q;

  logic                           s_fire;
  logic                           m_fire;
  logic                           row_last;
  logic                           mac_last;
  logic                           ovf;
  logic [YIW-1:0]                 k_nx;
  logic signed [PW-1:0]           prod;
  logic signed [AW-1:0]           acc_base;
  logic signed [AW-1:0]           sum;
  logic signed [WW-1:0]           sum_w;
  logic signed [OUTPUT_WIDTH-1:0] conv;

  always_comb begin
    s_fire   = s_valid && s_ready_q;
    m_fire   = m_valid_q && m_ready;
    row_last = (col_q == XIW'(COLS - 1));
    mac_last = (a_idx_q == AIW'(NA - 1));
    k_nx     = k_q + YIW'(1);
    prod     = a_q[a_idx_q] * x_q[col_q];
    acc_base = (col_q == '0) ? '0 : acc_q;
    sum      = acc_base + AW'(prod);
    sum_w    = WW'(sum);
    ovf      = (sum_w > MAXV) || (sum_w < MINV);
    if (SATURATE && (sum_w > MAXV)) begin
      conv = MAXV[OUTPUT_WIDTH-1:0];
    end else if (SATURATE && (sum_w < MINV)) begin
      conv = MINV[OUTPUT_WIDTH-1:0];
    end else begin
      conv = sum_w[OUTPUT_WIDTH-1:0];
    end
  end

  // Operand and result storage carries no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (state_q == LOAD_A && s_fire) a_q[a_idx_q] <= s_data;
    if (state_q == LOAD_X && s_fire) x_q[col_q] <= s_data;
    if (state_q == COMPUTE) begin
      acc_q <= sum;
      if (row_last) y_q[row_q] <= conv;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_idx_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      k_q       <= '0;
      mat_ok_q  <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      m_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // done_q blocks a start arriving in the same cycle as the done pulse
          if (start && !done_q) begin
            sat_q     <= 1'b0;
            busy_q    <= 1'b1;
            s_ready_q <= 1'b1;
            a_idx_q   <= '0;
            col_q     <= '0;
            if (keep_matrix && mat_ok_q) begin
              state_q <= LOAD_X;
            end else begin
              mat_ok_q <= 1'b0;
              state_q  <= LOAD_A;
            end
          end
        end
        LOAD_A: begin
          if (s_fire) begin
            if (mac_last) begin
              a_idx_q  <= '0;
              mat_ok_q <= 1'b1;
              state_q  <= LOAD_X;
            end else begin
              a_idx_q <= a_idx_q + AIW'(1);
            end
          end
        end
        LOAD_X: begin
          if (s_fire) begin
            if (row_last) begin
              col_q     <= '0;
              a_idx_q   <= '0;
              row_q     <= '0;
              s_ready_q <= 1'b0;
              state_q   <= COMPUTE;
            end else begin
              col_q <= col_q + XIW'(1);
            end
          end
        end
        COMPUTE: begin
          a_idx_q <= a_idx_q + AIW'(1);
          if (row_last) begin
            col_q <= '0;
            row_q <= row_q + YIW'(1);
            sat_q <= sat_q | ovf;
          end else begin
            col_q <= col_q + XIW'(1);
          end
          if (mac_last) begin
            a_idx_q   <= '0;
            row_q     <= '0;
            k_q       <= '0;
            m_valid_q <= 1'b1;
            m_data_q  <= (ROWS == 1) ? conv : y_q[0];
            state_q   <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (m_fire) begin
            if (k_q == YIW'(ROWS - 1)) begin
              k_q       <= '0;
              m_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              k_q      <= k_nx;
              m_data_q <= y_q[k_nx];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sat     = sat_q;
endmodule

// File: tb/tb_mvm_stream.sv
// Bench for mvm_stream: a 4x4 wrap/saturate pair fed in lockstep plus a 2x3 instance,
// directed table entries and randomized runs checked against an arithmetic reference.
module tb_mvm_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, keep, s_valid, m_ready;
  logic signed [7:0] s_data;
  int sel;
  logic st0, st2;
  assign st0 = start && (sel == 0);
  assign st2 = start && (sel == 1);

  logic s_ready0, m_valid0, busy0, done0, sat0;
  logic s_ready1, m_valid1, busy1, done1, sat1;
  logic s_ready2, m_valid2, busy2, done2, sat2;
  logic signed [15:0] m_data0, m_data1, m_data2;

  mvm_stream #(.ROWS(4), .COLS(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .SATURATE(1'b0)) u0 (
    .clk(clk), .reset(rst_n), .start(st0), .keep_matrix(keep), .s_valid(s_valid), .s_ready(s_ready0),
    .s_data(s_data), .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .busy(busy0),
    .done(done0), .sat(sat0));
  mvm_stream #(.ROWS(4), .COLS(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .SATURATE(1'b1)) u1 (
    .clk(clk), .reset(rst_n), .start(st0), .keep_matrix(keep), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .busy(busy1),
    .done(done1), .sat(sat1));
  mvm_stream #(.ROWS(2), .COLS(3), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .SATURATE(1'b0)) u2 (
    .clk(clk), .reset(rst_n), .start(st2), .keep_matrix(keep), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .busy(busy2),
    .done(done2), .sat(sat2));

  logic o_sready, o_mvalid, o_busy, o_done, o_sat;
  logic signed [15:0] o_mdata;
  always_comb begin
    if (sel == 1) begin
      o_sready = s_ready2; o_mvalid = m_valid2; o_busy = busy2; o_done = done2; o_sat = sat2; o_mdata = m_data2;
    end else begin
      o_sready = s_ready0; o_mvalid = m_valid0; o_busy = busy0; o_done = done0; o_sat = sat0; o_mdata = m_data0;
    end
  end

  int n_tests, n_fail;
  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // reference state: stored matrices per shape and expected results
  bit ok4, ok23;
  int A4[16];
  int A23[6];
  int cur_A[16];
  int cur_x[4];
  int exp_y[4];
  int exp_ys[4];
  bit exp_sat;
  int beats[$];
  int gap_g;

  function automatic void model(input int rows, input int cols);
    exp_sat = 1'b0;
    for (int r = 0; r < rows; r++) begin
      longint s;
      int w;
      s = 0;
      for (int c = 0; c < cols; c++) s += longint'(cur_A[r*cols+c]) * longint'(cur_x[c]);
      w = int'(s & 64'hFFFF);
      if (w > 32767) w -= 65536;
      exp_y[r] = w;
      exp_ys[r] = (s > 32767) ? 32767 : (s < -32768) ? -32768 : int'(s);
      if (s > 32767 || s < -32768) exp_sat = 1'b1;
    end
  endfunction

  task automatic feed(input int nb, output int acc);
    int cyc;
    bit fire;
    cyc = 0;
    acc = 0;
    while (acc < nb && cyc < 4000) begin
      s_valid = ($urandom_range(99) >= gap_g);
      s_data = 8'(beats[acc]);
      fire = s_valid && o_sready;
      @(negedge clk);
      cyc++;
      if (fire) acc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic do_run(input string nm, input int s, input bit kp, input bit poke,
                        input int gap, input int rdy, input bit use_model);
    int rows, cols, nb, acc, lat, k, cyc, done_cnt;
    bit stored, prev_stall;
    logic signed [15:0] prev_data;
    rows = (s == 1) ? 2 : 4;
    cols = (s == 1) ? 3 : 4;
    stored = kp && ((s == 1) ? ok23 : ok4);
    beats.delete();
    for (int i = 0; i < rows*cols; i++) begin
      if (stored) cur_A[i] = (s == 1) ? A23[i] : A4[i];
      else begin
        beats.push_back(cur_A[i]);
        if (s == 1) A23[i] = cur_A[i]; else A4[i] = cur_A[i];
      end
    end
    if (!stored) begin
      if (s == 1) ok23 = 1'b1; else ok4 = 1'b1;
    end
    for (int c = 0; c < cols; c++) beats.push_back(cur_x[c]);
    if (use_model) model(rows, cols);
    nb = beats.size();
    sel = s;
    gap_g = gap;
    m_ready = 1'b0;
    @(negedge clk); start = 1'b1; keep = kp;
    @(negedge clk); start = 1'b0; keep = 1'b0;
    check({nm, " busy"}, o_busy, 1);
    feed(nb, acc);
    check({nm, " beats"}, acc, nb);
    check({nm, " s_ready_after_load"}, o_sready, 0);
    lat = 0;
    while (!o_mvalid && lat < 1000) begin
      start = poke && (lat == 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({nm, " latency"}, lat, rows*cols);
    k = 0; cyc = 0; done_cnt = 0; prev_stall = 1'b0; prev_data = '0;
    while (k < rows && cyc < 1000) begin
      m_ready = ($urandom_range(99) >= rdy);
      start = poke && (cyc == 1);
      if (prev_stall) begin
        check({nm, " m_data_stable"}, o_mdata, prev_data);
        check({nm, " m_valid_held"}, o_mvalid, 1);
      end
      if (o_mvalid && m_ready) begin
        check($sformatf("%s y[%0d]", nm, k), o_mdata, exp_y[k]);
        if (s == 0) check($sformatf("%s ysat[%0d]", nm, k), m_data1, exp_ys[k]);
        k++;
      end
      prev_stall = o_mvalid && !m_ready;
      prev_data = o_mdata;
      @(negedge clk);
      cyc++;
      if (o_done) done_cnt++;
    end
    m_ready = 1'b0;
    check({nm, " outputs"}, k, rows);
    check({nm, " done_pulse"}, o_done, 1);
    check({nm, " m_valid_low"}, o_mvalid, 0);
    check({nm, " idle_busy"}, o_busy, 0);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    if (o_done) done_cnt++;
    check({nm, " start_on_done_ignored"}, o_busy, 0);
    repeat (2) begin
      @(negedge clk);
      if (o_done) done_cnt++;
    end
    check({nm, " done_count"}, done_cnt, 1);
    check({nm, " sat"}, o_sat, exp_sat);
    if (s == 0) check({nm, " sat_clamp"}, sat1, exp_sat);
  endtask

  typedef struct {
    string nm;
    int s;
    bit kp;
    bit pre_rst;
    bit poke;
    int gap;
    int rdy;
    int a[16];
    int x[4];
    int ey[4];
    int eys[4];
    bit esat;
  } vec_t;
  vec_t tbl[6];

  function automatic int rnd8();
    int r;
    r = int'($urandom_range(3));
    if (r == 0) return 127;
    if (r == 1) return -128;
    return int'($urandom_range(255)) - 128;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n = 1'b0; start = 1'b0; keep = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    sel = 0; n_tests = 0; n_fail = 0; ok4 = 1'b0; ok23 = 1'b0; gap_g = 0;
    #12;
    check("rst s_ready", s_ready0, 0);
    check("rst m_valid", m_valid0, 0);
    check("rst busy", busy0, 0);
    check("rst done", done0, 0);
    check("rst sat", sat0, 0);
    check("rst m_data", m_data0, 0);
    check("rst sat clamp inst", sat1, 0);
    check("rst m_data 2x3", m_data2, 0);
    check("rst busy 2x3", busy2, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      tbl[i].s = 0; tbl[i].kp = 0; tbl[i].pre_rst = 0; tbl[i].poke = 0;
      tbl[i].gap = 0; tbl[i].rdy = 0; tbl[i].esat = 0;
      for (int j = 0; j < 16; j++) tbl[i].a[j] = 0;
    end
    tbl[0].nm = "identity";
    for (int j = 0; j < 16; j++) tbl[0].a[j] = (j % 5 == 0) ? 1 : 0;
    tbl[0].x = '{1, -2, 3, -4}; tbl[0].ey = '{1, -2, 3, -4}; tbl[0].eys = '{1, -2, 3, -4};
    tbl[1].nm = "keep"; tbl[1].kp = 1;
    tbl[1].x = '{5, 6, 7, 8}; tbl[1].ey = '{5, 6, 7, 8}; tbl[1].eys = '{5, 6, 7, 8};
    tbl[2].nm = "all127"; tbl[2].esat = 1;
    for (int j = 0; j < 16; j++) tbl[2].a[j] = 127;
    tbl[2].x = '{127, 127, 127, 127};
    tbl[2].ey = '{-1020, -1020, -1020, -1020}; tbl[2].eys = '{32767, 32767, 32767, 32767};
    tbl[3].nm = "shape2x3"; tbl[3].s = 1; tbl[3].gap = 40; tbl[3].rdy = 50;
    tbl[3].a[0] = 1; tbl[3].a[1] = 2; tbl[3].a[2] = 3;
    tbl[3].a[3] = -1; tbl[3].a[4] = -1; tbl[3].a[5] = -1;
    tbl[3].x = '{-128, 0, 127, 0}; tbl[3].ey = '{253, 1, 0, 0}; tbl[3].eys = '{253, 1, 0, 0};
    tbl[4].nm = "reset_reload"; tbl[4].kp = 1; tbl[4].pre_rst = 1;
    for (int j = 0; j < 16; j++) tbl[4].a[j] = 1;
    tbl[4].x = '{-128, -128, -128, -128};
    tbl[4].ey = '{-512, -512, -512, -512}; tbl[4].eys = '{-512, -512, -512, -512};
    tbl[5].nm = "start_poke"; tbl[5].kp = 1; tbl[5].poke = 1; tbl[5].gap = 20; tbl[5].rdy = 50;
    tbl[5].x = '{-3, 4, -5, 6}; tbl[5].ey = '{2, 2, 2, 2}; tbl[5].eys = '{2, 2, 2, 2};

    for (int i = 0; i < 6; i++) begin
      cur_A = tbl[i].a; cur_x = tbl[i].x;
      exp_y = tbl[i].ey; exp_ys = tbl[i].eys; exp_sat = tbl[i].esat;
      if (tbl[i].pre_rst) begin
        sel = 0; gap_g = 0;
        beats.delete();
        for (int j = 0; j < 18; j++) beats.push_back((j < 16) ? cur_A[j] : 9);
        @(negedge clk); start = 1'b1; keep = 1'b0;
        @(negedge clk); start = 1'b0;
        feed(18, acc);
        check("reset_reload partial beats", acc, 18);
        rst_n = 1'b0;
        #1;
        check("async rst s_ready", s_ready0, 0);
        check("async rst busy", busy0, 0);
        @(negedge clk); rst_n = 1'b1;
        ok4 = 1'b0;
      end
      do_run(tbl[i].nm, tbl[i].s, tbl[i].kp, tbl[i].poke, tbl[i].gap, tbl[i].rdy, 1'b0);
    end

    for (int n = 0; n < 24; n++) begin
      for (int j = 0; j < 16; j++) cur_A[j] = rnd8();
      for (int j = 0; j < 4; j++) cur_x[j] = rnd8();
      do_run($sformatf("rand%0d", n), int'($urandom_range(1)), 1'($urandom_range(1)),
             1'($urandom_range(1)), int'($urandom_range(50)), int'($urandom_range(60)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
